// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 drive chain: ramp FSM state encoding
// and the frequency-word defaults used by both the ramp and the step generator.
package motoro3_pkg;

    localparam int unsigned FREQ_W_DEF = 10;
    localparam int unsigned F_MIN_DEF  = 1;
    localparam int unsigned DIV_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STOP  = 3'd4
    } ramp_state_e;

    // A zero acceleration request still has to make progress.
    function automatic logic [3:0] eff_step(input logic [3:0] step);
        return (step == 4'd0) ? 4'd1 : step;
    endfunction

endpackage

// File: rtl/motoro3_freq_ramp_if.sv
// Command, feedback and status bundle between the ramp controller and its
// operator-side driver.
interface motoro3_freq_ramp_if
    import motoro3_pkg::*;
#(
    parameter int unsigned FREQ_W = FREQ_W_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
);
    logic              cmdRun;
    logic [FREQ_W-1:0] cmdFreq;
    logic [3:0]        accelStep;
    logic [DIV_W-1:0]  rampDiv;
    logic              m3cntLast1;
    logic              m3start;
    logic [FREQ_W-1:0] m3freq;
    logic [FREQ_W-1:0] freqInt;
    logic [2:0]        rampState;
    logic              rampBusy;
    logic              atTarget;

    modport master (
        output cmdRun, cmdFreq, accelStep, rampDiv, m3cntLast1,
        input  m3start, m3freq, freqInt, rampState, rampBusy, atTarget
    );

    modport slave (
        input  cmdRun, cmdFreq, accelStep, rampDiv, m3cntLast1,
        output m3start, m3freq, freqInt, rampState, rampBusy, atTarget
    );

endinterface

// File: rtl/motoro3_ramp_tick.sv
// Ramp prescaler: one-cycle tick every rampDiv clocks while enabled,
// restartable from zero via clr.
module motoro3_ramp_tick #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] rampDiv,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_last;

    // A divider of 0 behaves as 1, i.e. a tick on every enabled cycle.
    assign w_last = (rampDiv == '0) ? '0 : rampDiv - DIV_W'(1);
    assign tick   = en && (r_cnt == w_last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/motoro3_freq_ramp.sv
// Soft-start frequency ramp: turns a run request and target into a
// rate-limited trajectory, committed to the step generator at cycle ends.
module motoro3_freq_ramp
    import motoro3_pkg::*;
#(
    parameter int unsigned FREQ_W = FREQ_W_DEF,
    parameter int unsigned F_MIN  = F_MIN_DEF,
    parameter int unsigned DIV_W  = DIV_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    motoro3_freq_ramp_if.slave  bus
);

    localparam logic [FREQ_W-1:0] FMIN_V = FREQ_W'(F_MIN);
    localparam int unsigned       XW     = FREQ_W + 1;

    ramp_state_e       r_state, w_next;
    logic              r_start;
    logic [FREQ_W-1:0] r_freq, r_m3freq;
    logic [FREQ_W-1:0] w_tgt_run, w_tgt, w_freq_next;
    logic [XW-1:0]     w_f, w_t, w_step, w_up;
    logic              w_tick, w_en, w_clr;

    assign w_tgt_run = (bus.cmdFreq < FMIN_V) ? FMIN_V : bus.cmdFreq;
    assign w_tgt     = (r_state == ST_STOP) ? FMIN_V : w_tgt_run;

    // Saturating step in one extra bit so neither direction can wrap.
    assign w_f    = {1'b0, r_freq};
    assign w_t    = {1'b0, w_tgt};
    assign w_step = XW'(eff_step(bus.accelStep));
    assign w_up   = w_f + w_step;

    always_comb begin
        w_freq_next = r_freq;
        if (w_f < w_t) begin
            w_freq_next = (w_up > w_t) ? w_tgt : FREQ_W'(w_up);
        end else if (w_f > w_t) begin
            w_freq_next = (w_f >= w_t + w_step) ? FREQ_W'(w_f - w_step) : w_tgt;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.cmdRun) w_next = ST_START;
            ST_START: w_next = ST_RAMP;
            ST_RAMP: begin
                if (!bus.cmdRun)              w_next = ST_STOP;
                else if (r_freq == w_tgt_run) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.cmdRun)              w_next = ST_STOP;
                else if (r_freq != w_tgt_run) w_next = ST_RAMP;
            end
            ST_STOP: begin
                if (bus.cmdRun)                                    w_next = ST_RAMP;
                else if (r_freq == FMIN_V && r_m3freq == FMIN_V)   w_next = ST_IDLE;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    assign w_en  = (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign w_clr = ((w_next == ST_RAMP) || (w_next == ST_STOP)) && (w_next != r_state);

    motoro3_ramp_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_en),
        .rampDiv (bus.rampDiv),
        .tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_start  <= 1'b0;
            r_freq   <= FMIN_V;
            r_m3freq <= FMIN_V;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == ST_RAMP) || (w_next == ST_RUN) || (w_next == ST_STOP);
            if (r_state == ST_IDLE) begin
                r_freq <= FMIN_V;
            end else if (w_tick) begin
                r_freq <= w_freq_next;
            end
            // Once running, only hand over a new frequency at a cycle boundary.
            if (!r_start || bus.m3cntLast1) begin
                r_m3freq <= r_freq;
            end
        end
    end

    assign bus.m3start   = r_start;
    assign bus.m3freq    = r_m3freq;
    assign bus.freqInt   = r_freq;
    assign bus.rampState = r_state;
    assign bus.rampBusy  = (r_state == ST_START) || (r_state == ST_RAMP) || (r_state == ST_STOP);
    assign bus.atTarget  = (r_state == ST_RUN);

endmodule

// File: doc/motoro3_freq_ramp.md
# motoro3_freq_ramp

Soft-start frequency ramp controller that sits directly upstream of `motoro3_state_machine` and drives its `m3start` / `m3freq` inputs. It turns an operator run request and target frequency into a rate-limited frequency trajectory: start, ramp up, hold, ramp down, stop. It also uses the step generator's `m3cntLast1` feedback so that a new frequency is only handed downstream at an electrical-cycle boundary.

## Interface
- `FREQ_W`, 10: frequency word width; matches `m3freq`.
- `F_MIN`, 1: minimum running frequency, and the start/stop frequency.
- `DIV_W`, 16: ramp prescaler width.

- `clk`  in  1  system clock, 10 MHz.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `cmdRun`  in  1  run request, level-sensitive.
- `cmdFreq`  in  FREQ_W  target frequency; values below `F_MIN` are clamped to `F_MIN`.
- `accelStep`  in  4  frequency change per ramp tick; 0 is treated as 1.
- `rampDiv`  in  DIV_W  clocks per ramp tick; 0 is treated as 1.
- `m3cntLast1`  in  1  end-of-cycle pulse from the step generator.
- `m3start`  out  1  enable to the step generator.
- `m3freq`  out  FREQ_W  committed frequency to the step generator.
- `freqInt`  out  FREQ_W  internal ramp value, for debug.
- `rampState`  out  3  current FSM state.
- `rampBusy`  out  1  high in START, RAMP and STOP.
- `atTarget`  out  1  high in RUN only.

## Operation
- **States** (3-bit encoding): IDLE=0, START=1, RAMP=2, RUN=3, STOP=4.
- **IDLE**
  - `m3start`=0; `freqInt` is held at `F_MIN`.
  - `cmdRun`=1 → START.
- **START**
  - Lasts exactly one cycle.
  - `m3start` goes to 1 on the next edge; `m3freq`=`F_MIN`.
  - → RAMP.
- **RAMP**
  - The target is the clamped `cmdFreq`, resampled on every tick, so a target change mid-ramp redirects the ramp.
  - On each tick, `freqInt` moves one step toward the target.
  - `freqInt`==target → RUN.
  - `cmdRun`=0 → STOP. This has priority over the RUN transition.
- **RUN**
  - `cmdRun`=0 → STOP.
  - Otherwise, clamped `cmdFreq` != `freqInt` → RAMP.
- **STOP**
  - The target is forced to `F_MIN`, and the ramp continues on ticks.
  - `cmdRun`=1 → RAMP (resume without passing through IDLE).
  - `freqInt`==`F_MIN` and `m3freq`==`F_MIN` → IDLE; `m3start` drops on the same edge.
- **Arithmetic** (computed in FREQ_W+1 bits, no wrap)
  - Ramping up: next = min(`freqInt`+step, target).
  - Ramping down: next = max(`freqInt`−step, target).
- **Prescaler**
  - Counts 0..`rampDiv`−1; the tick fires when count==`rampDiv`−1, then the counter returns to 0.
  - Runs only in RAMP and STOP, and is cleared on every entry to either state.
- **Commit rule**
  - While `m3start`=0, `m3freq` follows `freqInt` every cycle.
  - While `m3start`=1, `m3freq` loads `freqInt` only on cycles where `m3cntLast1`=1.
  - Consequently, STOP waits for the final commit of `F_MIN` before returning to IDLE.

## Timing
- **Reset values:**
  - state=IDLE, `m3start`=0, `m3freq`=`F_MIN`, `freqInt`=`F_MIN`, prescaler=0, `rampBusy`=0, `atTarget`=0.
- **Output registration:** all outputs are registered; `rampBusy` and `atTarget` are decoded from the registered state.
- **Start latency:** `cmdRun` rising → `m3start`=1 two edges later (IDLE→START→RAMP).
- **First ramp step:** the first tick after entering RAMP occurs `rampDiv` clocks after entry.
- **Commit latency:** `freqInt` → `m3freq` takes at most one step-generator cycle, and is 1 clock when `m3cntLast1` is tied high.
- **Simultaneous tick and `m3cntLast1`:** `m3freq` loads the pre-tick `freqInt`; the new value commits at the next `m3cntLast1`.
- **`rst` mid-operation:** all registers return to their reset values on the next edge and `m3start` drops immediately. No ramp-down is performed.

## Structure
- **Shared package `motoro3_pkg`:** holds the state encoding constants and the `F_MIN` / `FREQ_W` defaults, which are shared with the step generator.
- **Sub-module `motoro3_ramp_tick`:** the prescaler, with inputs `clk`, `rst`, `clr`, `en` and `rampDiv`, and output `tick`.
- **Top level:** the FSM, the saturating step datapath and the commit register live in `motoro3_freq_ramp`.

## Test plan
Unless a scenario overrides it, `F_MIN`=1 and `m3cntLast1` is tied to 1.

- **Basic ramp-up:** `rampDiv`=4, `accelStep`=10, `cmdFreq`=51, `cmdRun`↑.
  - `freqInt` follows 1, 11, 21, 31, 41, 51 at 4-clock intervals.
  - After the last step, `atTarget`=1 and `m3freq`=51.
- **Saturation:** `accelStep`=15, `cmdFreq`=20.
  - `freqInt` goes 1, 16, 20 and never overshoots.
  - `accelStep`=0 behaves as a step of 1.
- **Ramp-down and stop:** from RUN at 51, `cmdRun`↓ with `accelStep`=10.
  - `freqInt` goes 41, 31, 21, 11, 1, then IDLE.
  - `m3start`=0 on the same edge as the IDLE entry.
- **Commit gating:** `m3cntLast1` pulses every 100 clocks, `rampDiv`=4.
  - `m3freq` changes only on pulse cycles and skips intermediate values.
- **Resume and retarget:** `cmdRun` re-asserted in STOP at `freqInt`=31 → RAMP back up toward `cmdFreq`. Then `cmdFreq` changed 51→25 while in RUN → ramps down to 25 and returns to RUN.
- **Reset and clamping:** `rst` pulsed mid-RAMP → all outputs at reset values next edge. `cmdFreq`=0 → target clamped to 1.
